// File: rtl/booth_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | booth_divider: sequential signed 16/8 restoring divider, one bit per     |
// | cycle on magnitudes, then a sign-fix cycle. Option: DIV_OVF_PRECHECK_EN  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module booth_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    input  logic        go,
    output logic [7:0]  quot,
    output logic [7:0]  rem,
    output logic        err,
    output logic        over,
    output logic [1:0]  check_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q,   dvd_d;
    logic [8:0]  dvs_q,   dvs_d;
    logic        sdvd_q,  sdvd_d;
    logic        sdvs_q,  sdvs_d;
    logic [15:0] quo_q,   quo_d;
    logic [8:0]  pr_q,    pr_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [7:0]  quot_q,  quot_d;
    logic [7:0]  rem_q,   rem_d;
    logic        err_q,   err_d;
    logic        over_q,  over_d;

    logic [15:0] w_dvd_mag;
    logic [8:0]  w_dvs_ext;
    logic [8:0]  w_dvs_mag;
    logic [9:0]  w_pr_shift;
    logic        w_pr_ge;
    logic        w_neg;
    logic        w_ovf;
    logic [7:0]  w_qs;
    logic [7:0]  w_rem_s;
    logic        w_pre_ovf;

    always_comb begin
        w_dvd_mag  = dividend[15] ? (~dividend + 16'd1) : dividend;
        w_dvs_ext  = {divisor[7], divisor};
        w_dvs_mag  = divisor[7] ? (~w_dvs_ext + 9'd1) : w_dvs_ext;
        w_pr_shift = {pr_q, dvd_q[15]};
        w_pr_ge    = w_pr_shift >= {1'b0, dvs_q};
        w_neg      = sdvd_q ^ sdvs_q;
        // A negative result may reach -128, a positive one only +127.
        w_ovf      = w_neg ? (quo_q > 16'd128) : (quo_q > 16'd127);
        w_qs       = w_neg ? (~quo_q[7:0] + 8'd1) : quo_q[7:0];
        w_rem_s    = sdvd_q ? (~pr_q[7:0] + 8'd1) : pr_q[7:0];
`ifdef DIV_OVF_PRECHECK_EN
        w_pre_ovf  = {1'b0, w_dvd_mag[15:8]} >= w_dvs_mag;
`else
        w_pre_ovf  = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sdvd_d  = sdvd_q;
        sdvs_d  = sdvs_q;
        quo_d   = quo_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;
        over_d  = over_q;

        case (state_q)
            S_IDLE: begin
                over_d = 1'b0;
                if (go) begin
                    sdvd_d = dividend[15];
                    sdvs_d = divisor[7];
                    dvd_d  = w_dvd_mag;
                    dvs_d  = w_dvs_mag;
                    quo_d  = 16'd0;
                    pr_d   = 9'd0;
                    cnt_d  = 4'd15;
                    if ((divisor == 8'd0) || w_pre_ovf) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        quot_d  = 8'd0;
                        rem_d   = 8'd0;
                        over_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                pr_d  = w_pr_ge ? 9'(w_pr_shift - {1'b0, dvs_q}) : 9'(w_pr_shift);
                quo_d = {quo_q[14:0], w_pr_ge};
                dvd_d = {dvd_q[14:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (w_ovf) begin
                    err_d  = 1'b1;
                    quot_d = 8'd0;
                    rem_d  = 8'd0;
                end else begin
                    err_d  = 1'b0;
                    quot_d = w_qs;
                    rem_d  = w_rem_s;
                end
                over_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!go) begin
                    state_d = S_IDLE;
                    over_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dvd_q   <= 16'd0;
            dvs_q   <= 9'd0;
            sdvd_q  <= 1'b0;
            sdvs_q  <= 1'b0;
            quo_q   <= 16'd0;
            pr_q    <= 9'd0;
            cnt_q   <= 4'd0;
            quot_q  <= 8'd0;
            rem_q   <= 8'd0;
            err_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sdvd_q  <= sdvd_d;
            sdvs_q  <= sdvs_d;
            quo_q   <= quo_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            over_q  <= over_d;
        end
    end

    assign quot        = quot_q;
    assign rem         = rem_q;
    assign err         = err_q;
    assign over        = over_q;
    assign check_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_booth_divider: directed scoreboard bench for booth_divider            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_booth_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [7:0]  divisor = 8'd0;
    logic        go = 1'b0;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        err;
    logic        over;
    logic [1:0]  check_state;

    always #5 clk = ~clk;

    booth_divider dut (
        .clk        (clk),
        .reset      (reset),
        .dividend   (dividend),
        .divisor    (divisor),
        .go         (go),
        .quot       (quot),
        .rem        (rem),
        .err        (err),
        .over       (over),
        .check_state(check_state)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division truncating toward zero; latency counts edges from E0 to over.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   q;
        int   r;
        e.q = 8'd0; e.r = 8'd0; e.e = 1'b1; e.lat = 18;
        if (b == 0) begin
            e.lat = 1;
            return e;
        end
`ifdef DIV_OVF_PRECHECK_EN
        if ((((a < 0) ? -a : a) >>> 8) >= ((b < 0) ? -b : b)) begin
            e.lat = 1;
            return e;
        end
`endif
        q = a / b;
        r = a % b;
        if (q <= 127 && q >= -128) begin
            e.q = q[7:0];
            e.r = r[7:0];
            e.e = 1'b0;
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input int a, input int b, input int hold, input bit scramble);
        exp_t e;
        exp_t got;
        int   n;
        bit   seq_ok;
        logic [1:0] exp_st;
        e = model(a, b);
        @(negedge clk);
        dividend = a[15:0];
        divisor  = b[7:0];
        go       = 1'b1;
        sb.push_back(e);
        n = 0;
        seq_ok = 1'b1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (scramble && n == 3) begin
                dividend = ~dividend;
                divisor  = divisor ^ 8'h5A;
            end
            if (e.lat == 1)     exp_st = 2'd3;
            else if (n <= 16)   exp_st = 2'd1;
            else if (n == 17)   exp_st = 2'd2;
            else                exp_st = 2'd3;
            if (check_state !== exp_st) seq_ok = 1'b0;
            if (over === 1'b1) break;
        end
        chk({tag, " latency"}, n, e.lat);
        chk({tag, " state_seq"}, {31'd0, seq_ok}, 32'd1);
        got = sb.pop_front();
        chk({tag, " quot"}, {24'd0, quot}, {24'd0, got.q});
        chk({tag, " rem"},  {24'd0, rem},  {24'd0, got.r});
        chk({tag, " err"},  {31'd0, err},  {31'd0, got.e});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold"}, {12'd0, check_state, over, err, rem, quot},
                {12'd0, 2'd3, 1'b1, got.e, got.r, got.q});
        end
        go = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " release"}, {29'd0, check_state, over}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", {13'd0, quot, rem, err, over}, 32'd0);
        chk("reset state", {30'd0, check_state}, 32'd0);
        reset = 1'b1;

        run_op("15/3", 15, 3, 10, 1'b0);
        chk("15/3 literal", {24'd0, quot}, 32'h05);
        run_op("-7/2", -7, 2, 0, 1'b0);
        chk("-7/2 literal", {16'd0, quot, rem}, 32'hFDFF);
        run_op("-256/2", -256, 2, 0, 1'b0);
        run_op("-16384/-128", -16384, -128, 0, 1'b0);
        run_op("32767/127", 32767, 127, 0, 1'b0);
        run_op("1234/0", 1234, 0, 0, 1'b0);
        run_op("1000/3", 1000, 3, 0, 1'b0);
        run_op("-32768/-128", -32768, -128, 0, 1'b0);
        run_op("-1000/127", -1000, 127, 0, 1'b0);
        run_op("12345/99 scr", 12345, 99, 0, 1'b1);
        run_op("100/-7", 100, -7, 0, 1'b0);
        chk("100/-7 literal", {16'd0, quot, rem}, 32'hF202);

        // Abort an operation mid-RUN with reset, then restart.
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 8'd5;
        go       = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid run state", {30'd0, check_state}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid reset outs", {13'd0, quot, rem, err, over}, 32'd0);
        chk("mid reset state", {30'd0, check_state}, 32'd0);
        reset = 1'b1;
        run_op("20/4", 20, 4, 0, 1'b0);
        chk("20/4 literal", {16'd0, quot, rem}, 32'h0500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
